// File: rtl/sort_arb_pkg.sv
// sort_arb_pkg: shared types and sizing for the two-requester sorter arbiter.
package sort_arb_pkg;

    localparam int DATA_W = 32;
    localparam int N_ELEMS = 5;
    localparam int CNT_W = $clog2(N_ELEMS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEMS - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

endpackage

// File: rtl/sort_arb_rr.sv
// sort_arb_rr: 2-way round-robin picker; rr_ptr breaks ties when both request.
module sort_arb_rr (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       gnt_id,
    output logic       any
);

    always_comb begin
        any    = |req;
        gnt_id = (&req) ? rr_ptr : req[1];
    end

endmodule

// File: rtl/sort_share_arbiter.sv
// sort_share_arbiter: time-shares one bubble sorter between two requesters,
// feeding and draining whole batches so they never interleave inside the sorter.
module sort_share_arbiter
    import sort_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_put_valid,
    input  logic [DATA_W-1:0] r0_put_data,
    output logic              r0_put_ready,
    output logic              r0_get_valid,
    output logic [DATA_W-1:0] r0_get_data,
    output logic              r0_get_last,
    input  logic              r0_get_ready,
    input  logic              r1_put_valid,
    input  logic [DATA_W-1:0] r1_put_data,
    output logic              r1_put_ready,
    output logic              r1_get_valid,
    output logic [DATA_W-1:0] r1_get_data,
    output logic              r1_get_last,
    input  logic              r1_get_ready,
    output logic [DATA_W-1:0] sorter_put_x,
    output logic              sorter_en_put,
    input  logic              sorter_rdy_put,
    input  logic [DATA_W-1:0] sorter_get,
    output logic              sorter_en_get,
    input  logic              sorter_rdy_get,
    output logic              busy,
    output logic              grant_id,
    output logic              batch_done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             grant_id_q, grant_id_d;

    logic gnt_id, req_any;
    logic sel_put_valid, sel_get_ready;
    logic put_ready, get_valid, get_last;

    sort_arb_rr u_rr (
        .req    ({r1_put_valid, r0_put_valid}),
        .rr_ptr (rr_ptr_q),
        .gnt_id (gnt_id),
        .any    (req_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= 1'b0;
            grant_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        put_ready     = 1'b0;
        get_valid     = 1'b0;
        get_last      = 1'b0;
        sorter_en_put = 1'b0;
        sorter_en_get = 1'b0;
        batch_done    = 1'b0;
        sel_put_valid = grant_id_q ? r1_put_valid : r0_put_valid;
        sel_get_ready = grant_id_q ? r1_get_ready : r0_get_ready;
        unique case (state_q)
            IDLE: begin
                // Grant is only registered here; no element moves this cycle.
                if (req_any) begin
                    grant_id_d = gnt_id;
                    state_d    = FEED;
                end
            end
            FEED: begin
                put_ready     = sorter_rdy_put;
                sorter_en_put = sel_put_valid && sorter_rdy_put;
                if (sorter_en_put) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                get_valid     = sorter_rdy_get;
                get_last      = get_valid && (cnt_q == LAST_IDX);
                sorter_en_get = sorter_rdy_get && sel_get_ready;
                if (sorter_en_get) begin
                    if (cnt_q == LAST_IDX) begin
                        batch_done = 1'b1;
                        rr_ptr_d   = ~grant_id_q;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sorter_put_x = grant_id_q ? r1_put_data : r0_put_data;
    assign r0_put_ready = put_ready && !grant_id_q;
    assign r1_put_ready = put_ready && grant_id_q;
    assign r0_get_valid = get_valid && !grant_id_q;
    assign r1_get_valid = get_valid && grant_id_q;
    assign r0_get_last  = get_last && !grant_id_q;
    assign r1_get_last  = get_last && grant_id_q;
    assign r0_get_data  = sorter_get;
    assign r1_get_data  = sorter_get;
    assign busy         = state_q != IDLE;
    assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_sort_share_arbiter.sv
// tb_sort_share_arbiter: directed bench with a behavioural 5-deep bubble sorter
// model behind the arbiter.
module tb_sort_share_arbiter;
    import sort_arb_pkg::*;

    logic clk, rst_n;
    logic r0_put_valid, r0_put_ready, r0_get_valid, r0_get_last, r0_get_ready;
    logic r1_put_valid, r1_put_ready, r1_get_valid, r1_get_last, r1_get_ready;
    logic [31:0] r0_put_data, r0_get_data, r1_put_data, r1_get_data;
    logic [31:0] sorter_put_x, sorter_get;
    logic sorter_en_put, sorter_rdy_put, sorter_en_get, sorter_rdy_get;
    logic busy, grant_id, batch_done;

    int n_chk = 0, n_fail = 0;
    int viol = 0, r1_rdy_cnt = 0, n_done = 0;
    logic grants[$];

    sort_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_put_valid(r0_put_valid), .r0_put_data(r0_put_data), .r0_put_ready(r0_put_ready),
        .r0_get_valid(r0_get_valid), .r0_get_data(r0_get_data), .r0_get_last(r0_get_last),
        .r0_get_ready(r0_get_ready),
        .r1_put_valid(r1_put_valid), .r1_put_data(r1_put_data), .r1_put_ready(r1_put_ready),
        .r1_get_valid(r1_get_valid), .r1_get_data(r1_get_data), .r1_get_last(r1_get_last),
        .r1_get_ready(r1_get_ready),
        .sorter_put_x(sorter_put_x), .sorter_en_put(sorter_en_put), .sorter_rdy_put(sorter_rdy_put),
        .sorter_get(sorter_get), .sorter_en_get(sorter_en_get), .sorter_rdy_get(sorter_rdy_get),
        .busy(busy), .grant_id(grant_id), .batch_done(batch_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sorter model: collects 5 values, then hands them out in ascending order.
    logic [4:0][31:0] s_buf, s_sorted;
    logic [2:0] s_cnt;
    logic s_full;

    function automatic logic [4:0][31:0] sort5(input logic [4:0][31:0] a);
        logic [31:0] t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j];
                    a[j] = a[j+1];
                    a[j+1] = t;
                end
        return a;
    endfunction

    assign s_sorted       = sort5(s_buf);
    assign sorter_rdy_put = rst_n && !s_full;
    assign sorter_rdy_get = s_full;
    assign sorter_get     = s_sorted[s_cnt];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt  <= '0;
            s_full <= 1'b0;
            s_buf  <= '0;
        end else if (!s_full && sorter_en_put) begin
            s_buf[s_cnt] <= sorter_put_x;
            s_cnt  <= (s_cnt == 3'd4) ? 3'd0 : s_cnt + 3'd1;
            s_full <= (s_cnt == 3'd4);
        end else if (s_full && sorter_en_get) begin
            s_cnt  <= (s_cnt == 3'd4) ? 3'd0 : s_cnt + 3'd1;
            s_full <= (s_cnt != 3'd4);
        end
    end

    // Protocol watch: method guards, idle silence, and isolation of the loser.
    always @(posedge clk) begin
        if (rst_n) begin
            if ((sorter_en_put && !sorter_rdy_put) || (sorter_en_get && !sorter_rdy_get)
                || (!busy && (r0_put_ready | r1_put_ready | r0_get_valid | r1_get_valid
                              | sorter_en_put | sorter_en_get))
                || (busy && (grant_id ? (r0_put_ready | r0_get_valid)
                                      : (r1_put_ready | r1_get_valid))))
                viol <= viol + 1;
            if (r1_put_ready) r1_rdy_cnt <= r1_rdy_cnt + 1;
            if (batch_done) begin
                n_done <= n_done + 1;
                grants.push_back(grant_id);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_put(input bit r, input bit v, input int d);
        if (r) begin r1_put_valid = v; r1_put_data = d; end
        else begin r0_put_valid = v; r0_put_data = d; end
    endtask

    task automatic set_rdy(input bit r, input bit v);
        if (r) r1_get_ready = v;
        else r0_get_ready = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic put_elem(input bit r, input int d);
        int t = 0;
        set_put(r, 1'b1, d);
        #1;
        while (!(r ? r1_put_ready : r0_put_ready) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("put_timeout", t < 40, 1);
        chk("put_x", sorter_put_x, d);
        chk("en_put", sorter_en_put, 1);
        @(negedge clk);
    endtask

    task automatic feed(input bit r, input int v[5], input bit keep, input int stall_after);
        for (int i = 0; i < 5; i++) begin
            put_elem(r, v[i]);
            if (i == stall_after) begin
                set_put(r, 1'b0, 0);
                for (int k = 0; k < 3; k++) begin
                    #1;
                    chk("stall_cnt", dut.cnt_q, i + 1);
                    chk("stall_grant", grant_id, r);
                    chk("stall_busy", busy, 1);
                    chk("stall_other_rdy", r ? r0_put_ready : r1_put_ready, 0);
                    @(negedge clk);
                end
            end
        end
        if (!keep) set_put(r, 1'b0, 0);
    endtask

    task automatic drain(input bit r, input int e[5], input int stall_at);
        for (int i = 0; i < 5; i++) begin
            int t = 0;
            if (i == stall_at) begin
                set_rdy(r, 1'b0);
                for (int k = 0; k < 4; k++) begin
                    #1;
                    chk("dstall_en_get", sorter_en_get, 0);
                    chk("dstall_valid", r ? r1_get_valid : r0_get_valid, 1);
                    chk("dstall_data", r ? r1_get_data : r0_get_data, e[i]);
                    chk("dstall_cnt", dut.cnt_q, i);
                    @(negedge clk);
                end
            end
            set_rdy(r, 1'b1);
            #1;
            while (!(r ? r1_get_valid : r0_get_valid) && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("get_timeout", t < 40, 1);
            chk("get_data", r ? r1_get_data : r0_get_data, e[i]);
            chk("get_last", r ? r1_get_last : r0_get_last, i == 4);
            chk("batch_done", batch_done, i == 4);
            @(negedge clk);
        end
        set_rdy(r, 1'b0);
    endtask

    initial begin
        int va[5], ve[5];
        int d0, r1c, g0, t;
        rst_n = 1'b0;
        set_put(0, 0, 0); set_put(1, 0, 0);
        r0_get_ready = 1'b0; r1_get_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_done", batch_done, 0);
        chk("rst_en_put", sorter_en_put, 0);
        chk("rst_state", dut.state_q, IDLE);
        chk("rst_cnt", dut.cnt_q, 0);
        rst_n = 1'b1;

        // 1: single requester
        set_put(0, 1, 9);
        #1;
        chk("idle_no_ready", r0_put_ready, 0);
        d0 = n_done;
        va = '{9, 3, 7, 1, 5}; ve = '{1, 3, 5, 7, 9};
        feed(0, va, 0, -1);
        chk("t1_state", dut.state_q, DRAIN);
        chk("t1_grant", grant_id, 0);
        drain(0, ve, -1);
        chk("t1_ndone", n_done - d0, 1);
        chk("t1_rr", dut.rr_ptr_q, 1);
        chk("t1_busy", busy, 0);

        // 2: both requesting from reset
        set_put(0, 1, 6); set_put(1, 1, 4);
        do_reset();
        r1c = r1_rdy_cnt;
        va = '{6, 2, 8, 1, 3}; ve = '{1, 2, 3, 6, 8};
        feed(0, va, 0, -1);
        drain(0, ve, -1);
        chk("t2_r1_early", r1_rdy_cnt - r1c, 0);
        va = '{4, 4, 0, 2, 8}; ve = '{0, 2, 4, 4, 8};
        feed(1, va, 0, -1);
        chk("t2_grant", grant_id, 1);
        drain(1, ve, -1);

        // 3: r0 stalls mid-feed while r1 waits; 4: r1 stalls mid-drain
        set_put(1, 1, 7);
        va = '{5, 5, 1, 9, 0}; ve = '{0, 1, 5, 5, 9};
        feed(0, va, 0, 1);
        drain(0, ve, -1);
        va = '{7, 6, 5, 4, 3}; ve = '{3, 4, 5, 6, 7};
        feed(1, va, 0, -1);
        drain(1, ve, 2);

        // 5: asynchronous reset after three accepts
        for (int i = 0; i < 3; i++) put_elem(0, 100 + i);
        set_put(0, 0, 0);
        chk("t5_pre_cnt", dut.cnt_q, 3);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_state", dut.state_q, IDLE);
        chk("t5_cnt", dut.cnt_q, 0);
        chk("t5_ready", r0_put_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        va = '{10, 50, 30, 20, 40}; ve = '{10, 20, 30, 40, 50};
        feed(0, va, 0, -1);
        drain(0, ve, -1);

        // 6: back-to-back contention alternates grants
        set_put(0, 1, 15); set_put(1, 1, 25);
        do_reset();
        d0 = n_done;
        g0 = grants.size();
        for (int b = 0; b < 4; b++) begin
            int base = 10 * (b + 1);
            t = 0;
            #1;
            while (!busy && t < 20) begin
                @(negedge clk);
                #1;
                t++;
            end
            chk("t6_busy_timeout", t < 20, 1);
            chk("t6_grant", grant_id, b % 2);
            va = '{base + 5, base + 1, base + 4, base + 2, base + 3};
            ve = '{base + 1, base + 2, base + 3, base + 4, base + 5};
            feed(b[0], va, 1, -1);
            drain(b[0], ve, -1);
        end
        set_put(0, 0, 0); set_put(1, 0, 0);
        chk("t6_ndone", n_done - d0, 4);
        for (int b = 0; b < 4; b++)
            chk("t6_grant_seq", (grants.size() > g0 + b) ? grants[g0 + b] : 1'bx, b % 2);
        repeat (3) @(negedge clk);
        chk("protocol_viol", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
